// File: rtl/pulse_measure.sv
// Pulse width / period meter for the PulseCatch filtered feedback level.
// Results leave through a valid/ready port with sticky overrun and no-edge timeout flags.
module pulse_measure #(
    parameter int unsigned _RAM_WIDTH = 32
) (
    input  logic                  io_clk,
    input  logic                  io_rst,
    input  logic                  io_fb_catch,
    input  logic                  io_defaultLevel,
    input  logic                  io_enable,
    input  logic [_RAM_WIDTH-1:0] io_timeoutCnt,
    input  logic                  io_ready,
    output logic                  io_valid,
    output logic [_RAM_WIDTH-1:0] io_width,
    output logic [_RAM_WIDTH-1:0] io_period,
    output logic                  io_overrun,
    output logic                  io_timeout,
    output logic                  io_busy
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ACTIVE   = 2'd1,
        ST_INACTIVE = 2'd2
    } state_t;

    localparam logic [_RAM_WIDTH-1:0] ONE = {{(_RAM_WIDTH-1){1'b0}}, 1'b1};

    function automatic logic [_RAM_WIDTH-1:0] sat_inc(input logic [_RAM_WIDTH-1:0] v);
        return (v == '1) ? v : v + ONE;
    endfunction

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_lvl_d;
    logic                  r_dflt_d;
    logic [_RAM_WIDTH-1:0] r_wcnt;
    logic [_RAM_WIDTH-1:0] r_pcnt;
    logic [_RAM_WIDTH-1:0] r_whold;
    logic                  r_valid;
    logic [_RAM_WIDTH-1:0] r_width;
    logic [_RAM_WIDTH-1:0] r_period;
    logic                  r_overrun;
    logic                  r_timeout;

    logic w_act;
    logic w_lead;
    logic w_trail;
    logic w_dflt_chg;
    logic w_limit;
    logic w_arm;
    logic w_capture;
    logic w_inc_w;
    logic w_inc_p;
    logic w_publish;
    logic w_expire;

    always_comb begin
        w_act      = (io_fb_catch != io_defaultLevel);
        w_lead     = w_act & (r_lvl_d == io_defaultLevel);
        w_trail    = ~w_act & (r_lvl_d != io_defaultLevel);
        w_dflt_chg = (r_dflt_d != io_defaultLevel);
        // a lead on the limit cycle wins over the timeout
        w_limit    = (io_timeoutCnt != '0) && (r_pcnt == io_timeoutCnt) && !w_lead;
    end

    always_ff @(posedge io_clk) begin
        if (io_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_arm       = 1'b0;
        w_capture   = 1'b0;
        w_inc_w     = 1'b0;
        w_inc_p     = 1'b0;
        w_publish   = 1'b0;
        w_expire    = 1'b0;
        if (!io_enable || w_dflt_chg) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_lead) begin
                        w_state_nxt = ST_ACTIVE;
                        w_arm       = 1'b1;
                    end
                end
                ST_ACTIVE: begin
                    if (w_limit) begin
                        w_state_nxt = ST_IDLE;
                        w_expire    = 1'b1;
                    end else if (w_trail) begin
                        w_state_nxt = ST_INACTIVE;
                        w_capture   = 1'b1;
                        w_inc_p     = 1'b1;
                    end else begin
                        w_inc_w     = 1'b1;
                        w_inc_p     = 1'b1;
                    end
                end
                ST_INACTIVE: begin
                    if (w_lead) begin
                        w_state_nxt = ST_ACTIVE;
                        w_publish   = 1'b1;
                        w_arm       = 1'b1;
                    end else if (w_limit) begin
                        w_state_nxt = ST_IDLE;
                        w_expire    = 1'b1;
                    end else begin
                        w_inc_p     = 1'b1;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge io_clk) begin
        // edge history keeps tracking through reset and disable so no stale edge appears
        r_lvl_d  <= io_fb_catch;
        r_dflt_d <= io_defaultLevel;
        if (io_rst) begin
            r_wcnt    <= '0;
            r_pcnt    <= '0;
            r_whold   <= '0;
            r_valid   <= 1'b0;
            r_width   <= '0;
            r_period  <= '0;
            r_overrun <= 1'b0;
            r_timeout <= 1'b0;
        end else if (!io_enable) begin
            r_wcnt    <= '0;
            r_pcnt    <= '0;
            r_whold   <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            if (w_arm) begin
                r_wcnt <= ONE;
                r_pcnt <= ONE;
            end else begin
                if (w_inc_w) r_wcnt <= sat_inc(r_wcnt);
                if (w_inc_p) r_pcnt <= sat_inc(r_pcnt);
            end
            if (w_capture) r_whold <= r_wcnt;
            if (w_publish) begin
                r_width   <= r_whold;
                r_period  <= r_pcnt;
                r_valid   <= 1'b1;
                r_timeout <= 1'b0;
                if (r_valid && !io_ready) r_overrun <= 1'b1;
            end else if (r_valid && io_ready) begin
                r_valid <= 1'b0;
            end
            if (w_expire) r_timeout <= 1'b1;
        end
    end

    assign io_valid   = r_valid;
    assign io_width   = r_width;
    assign io_period  = r_period;
    assign io_overrun = r_overrun;
    assign io_timeout = r_timeout;
    assign io_busy    = (r_state != ST_IDLE);

endmodule
